jts16_sndlatch: RTL and testbench

JTS16_SNDLATCH -- requirements
Module: jts16_sndlatch

---
 rtl/jts16_pkg.sv | 9 +
 rtl/jts16_cmd_fifo.sv | 46 ++++
 rtl/jts16_sndlatch.sv | 80 ++++++++
 tb/tb_jts16_sndlatch.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/jts16_pkg.sv
// jts16_pkg: shared register map, port bit positions and command FIFO depth for the System 16 sound latch.
package jts16_pkg;
  typedef enum logic [1:0] {REG_PA, REG_PB, REG_PC, REG_CTRL} reg_e;
  localparam int FIFO_DEPTH  = 4;
  localparam int PB_FLIP     = 7;
  localparam int PB_VIDEO_EN = 4;
  localparam int PC_SND_RST  = 7;
  localparam int PC_OVF      = 6;
endpackage

// File: rtl/jts16_cmd_fifo.sv
// jts16_cmd_fifo: sound command store; DEPTH=1 behaves as an overwriting latch.
module jts16_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       ovf
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int MD = 2 ** PW;
  logic [7:0]    mem [MD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, do_pop, do_wr, adv_wr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    full   = cnt == CW'(DEPTH);
    empty  = cnt == '0;
    do_pop = pop & ~empty;
    adv_wr = push & (~full | do_pop);
    // a full latch still takes the new command; only a deeper FIFO drops it
    do_wr  = adv_wr | (push & DEPTH == 1);
    ovf    = push & full & ~do_pop;
    head   = mem[rd_ptr];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < MD; i++) mem[i] <= '0;
    end else begin
      if (do_wr) mem[wr_ptr] <= din;
      if (adv_wr) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(adv_wr) - CW'(do_pop);
    end
endmodule

// File: rtl/jts16_sndlatch.sv
// jts16_sndlatch: main-to-sound CPU command latch and I/O ports B/C.
// Define JTS16_SNDLATCH_FIFO_EN for a 4-entry command FIFO; otherwise a single latch.
module jts16_sndlatch
  import jts16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       io_cs,
  input  logic [1:0] addr,
  input  logic       LDSWn,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       snd_rd,
  output logic [7:0] snd_cmd,
  output logic       snd_nmi_n,
  output logic       flip,
  output logic       video_en,
  output logic       snd_rst
);
`ifdef JTS16_SNDLATCH_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  reg_e       sel;
  logic       req, wr, push, pop, wr_last, snd_rd_l, ovf, fifo_ovf, empty;
  logic [7:0] port_b, port_c, last_cmd, held, head, rd_c;
  always_comb begin
    sel       = reg_e'(addr);
    req       = io_cs & ~LDSWn;
    wr        = cpu_cen & req & ~wr_last;
    push      = wr & sel == REG_PA;
    pop       = snd_rd & ~snd_rd_l;
    rd_c      = port_c;
    rd_c[PC_OVF] = ovf;
    snd_cmd   = snd_rd_l ? held : head;
    snd_nmi_n = empty;
    flip      = port_b[PB_FLIP];
    video_en  = port_b[PB_VIDEO_EN];
    snd_rst   = port_c[PC_SND_RST];
  end
  jts16_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (din),
    .head (head),
    .empty(empty),
    .ovf  (fifo_ovf)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_last  <= 1'b0;
      snd_rd_l <= 1'b0;
      ovf      <= 1'b0;
      port_b   <= '0;
      port_c   <= '0;
      last_cmd <= '0;
      held     <= '0;
      dout     <= '0;
    end else begin
      // the access stays armed across cycles without cpu_cen so one bus access commits once
      wr_last  <= cpu_cen ? req : wr_last & req;
      snd_rd_l <= snd_rd;
      if (!snd_rd_l) held <= head;
      if (push) last_cmd <= din;
      if (fifo_ovf) ovf <= 1'b1;
      if (wr && sel == REG_PB) port_b <= din;
      if (wr && sel == REG_CTRL) begin
        if (din[7]) begin
          port_b <= '0;
          port_c <= '0;
          ovf    <= 1'b0;
        end else port_c[din[3:1]] <= din[0];
      end
      dout <= sel == REG_PA ? last_cmd : sel == REG_PB ? port_b : sel == REG_PC ? rd_c : 8'hff;
    end
endmodule

// File: tb/tb_jts16_sndlatch.sv
// tb_jts16_sndlatch: directed scoreboard bench for the sound latch, latch or FIFO build.
module tb_jts16_sndlatch;
`ifdef JTS16_SNDLATCH_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic       clk = 1'b0, rst = 1'b1, cpu_cen = 1'b1, io_cs = 1'b0, LDSWn = 1'b1, snd_rd = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout, snd_cmd;
  logic       snd_nmi_n, flip, video_en, snd_rst;
  int         checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] e;
  always #5 clk = ~clk;
  jts16_sndlatch dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .io_cs(io_cs), .addr(addr), .LDSWn(LDSWn),
    .din(din), .dout(dout), .snd_rd(snd_rd), .snd_cmd(snd_cmd), .snd_nmi_n(snd_nmi_n),
    .flip(flip), .video_en(video_en), .snd_rst(snd_rst)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic m_push(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else if (DEPTH == 1) q[0] = d;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_cs = 1'b1; LDSWn = 1'b0; addr = a; din = d;
    tick;
    io_cs = 1'b0; LDSWn = 1'b1;
    tick;
    if (a == 2'd0) m_push(d);
  endtask
  task automatic rd(input logic [1:0] a, input string tag, input logic [7:0] exp);
    addr = a;
    tick;
    chk(tag, dout, exp);
  endtask
  task automatic pop_chk(input string tag);
    logic [7:0] x;
    x = q.pop_front();
    snd_rd = 1'b1;
    tick;
    chk({tag, "_cmd"}, snd_cmd, x);
    tick;
    chk({tag, "_hold"}, snd_cmd, x);
    snd_rd = 1'b0;
    tick;
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_dout", dout, 8'h00);
    chk("rst_cmd", snd_cmd, 8'h00);
    chk("rst_nmi", {7'd0, snd_nmi_n}, 8'h01);
    chk("rst_flip", {7'd0, flip}, 8'h00);
    chk("rst_ven", {7'd0, video_en}, 8'h00);
    chk("rst_srst", {7'd0, snd_rst}, 8'h00);
    rst = 1'b0;
    tick;
    wr(2'd0, 8'h5A);
    chk("w5a_nmi", {7'd0, snd_nmi_n}, 8'h00);
    chk("w5a_cmd", snd_cmd, 8'h5A);
    pop_chk("w5a_pop");
    chk("w5a_nmi_hi", {7'd0, snd_nmi_n}, 8'h01);
    rd(2'd0, "rd_last", 8'h5A);
    rd(2'd3, "rd_ff", 8'hFF);
    for (int i = 1; i <= 5; i++) wr(2'd0, 8'(i));
    chk("fill_nmi", {7'd0, snd_nmi_n}, 8'h00);
    rd(2'd2, "fill_ovf", 8'h40);
    rd(2'd0, "fill_last", 8'h05);
    while (q.size() > 0) pop_chk("fill_pop");
    chk("fill_empty", {7'd0, snd_nmi_n}, 8'h01);
    wr(2'd3, 8'h80);
    rd(2'd2, "ovf_clr", 8'h00);
    wr(2'd0, 8'hA1);
    io_cs = 1'b1; LDSWn = 1'b0; addr = 2'd0; din = 8'hA2; snd_rd = 1'b1;
    tick;
    io_cs = 1'b0; LDSWn = 1'b1;
    e = q.pop_front();
    m_push(8'hA2);
    chk("pp_held", snd_cmd, e);
    chk("pp_nmi", {7'd0, snd_nmi_n}, 8'h00);
    tick;
    chk("pp_hold", snd_cmd, e);
    snd_rd = 1'b0;
    tick;
    chk("pp_new", snd_cmd, 8'hA2);
    chk("pp_nmi2", {7'd0, snd_nmi_n}, 8'h00);
    pop_chk("pp_pop");
    chk("pp_empty", {7'd0, snd_nmi_n}, 8'h01);
    wr(2'd3, 8'h0F);
    chk("srst_set", {7'd0, snd_rst}, 8'h01);
    rd(2'd2, "pc_80", 8'h80);
    wr(2'd3, 8'h0E);
    chk("srst_clr", {7'd0, snd_rst}, 8'h00);
    wr(2'd3, 8'h05);
    wr(2'd3, 8'h0F);
    rd(2'd2, "pc_84", 8'h84);
    wr(2'd3, 8'h80);
    chk("mode_srst", {7'd0, snd_rst}, 8'h00);
    rd(2'd2, "mode_pc", 8'h00);
    io_cs = 1'b1; LDSWn = 1'b0; addr = 2'd0; din = 8'h77;
    for (int i = 0; i < 6; i++) begin
      cpu_cen = (i % 2 == 0);
      tick;
    end
    io_cs = 1'b0; LDSWn = 1'b1; cpu_cen = 1'b1;
    tick;
    m_push(8'h77);
    rd(2'd2, "hold_ovf", 8'h00);
    pop_chk("hold_pop");
    chk("hold_once", {7'd0, snd_nmi_n}, 8'h01);
    wr(2'd1, 8'h90);
    chk("pb_flip", {7'd0, flip}, 8'h01);
    chk("pb_ven", {7'd0, video_en}, 8'h01);
    rd(2'd1, "pb_rd", 8'h90);
    wr(2'd0, 8'h33);
    chk("mid_nmi", {7'd0, snd_nmi_n}, 8'h00);
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("mid_dout", dout, 8'h00);
    chk("mid_cmd", snd_cmd, 8'h00);
    chk("mid_nmi_hi", {7'd0, snd_nmi_n}, 8'h01);
    chk("mid_flip", {7'd0, flip}, 8'h00);
    chk("mid_ven", {7'd0, video_en}, 8'h00);
    chk("mid_srst", {7'd0, snd_rst}, 8'h00);
    tick;
    rst = 1'b0;
    tick;
    chk("post_nmi", {7'd0, snd_nmi_n}, 8'h01);
    rd(2'd0, "post_last", 8'h00);
    rd(2'd1, "post_pb", 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
